// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM port controller: controller state encoding
// and the width helper used for response-FIFO occupancy counters.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Small synchronous response FIFO with occupancy count; head is always
// presented on rd_data so the consumer sees data as soon as count != 0.
module rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int RSP_DEPTH = 3
) (
    input  logic                               clk0,
    input  logic                               rst0,
    input  logic                               push,
    input  logic [WIDTH-1:0]                   push_data,
    input  logic                               pop,
    output logic [WIDTH-1:0]                   rd_data,
    output logic [cnt_width(RSP_DEPTH)-1:0]    count
);

    localparam int CW = cnt_width(RSP_DEPTH);
    localparam logic [CW-1:0] LAST  = CW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH = CW'(RSP_DEPTH);

    logic [WIDTH-1:0] mem [RSP_DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [CW-1:0] bump(input logic [CW-1:0] p);
        return (p == LAST) ? '0 : p + CW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != DEPTH) || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for a single-port array macro: request channel
// to csb/web port protocol, clear sweeps, and backpressured read responses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | one idle cycle after reset release
// ST_CLEAR | sweep every set with CLEAR_VALUE, requests blocked
// ST_RUN   | normal request service
// ST_DRAIN | clear requested; wait until no read is in flight
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int               S_INDEX     = 4,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
    parameter int               RSP_DEPTH   = 3
) (
    input  logic               clk0,
    input  logic               rst0,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [S_INDEX-1:0] req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_rdata,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               sram_csb,
    output logic               sram_web,
    output logic [S_INDEX-1:0] sram_addr,
    output logic [WIDTH-1:0]   sram_din,
    input  logic [WIDTH-1:0]   sram_dout
);

    localparam int               NUM_SETS = 2 ** S_INDEX;
    localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(NUM_SETS - 1);
    localparam int               CW       = cnt_width(RSP_DEPTH);
    localparam logic [CW:0]      DEPTH_L  = (CW + 1)'(RSP_DEPTH);

    state_t             state;
    state_t             state_nxt;
    logic [S_INDEX-1:0] clr_cnt;
    logic [S_INDEX-1:0] clr_cnt_nxt;
    logic               inflight;
    logic               accept;
    logic               rd_room;
    logic [CW-1:0]      fifo_count;

    // Reserve a FIFO slot for the read still in the array pipeline, so a full
    // FIFO never has to drop returning data; rsp_ready is deliberately ignored.
    assign rd_room = ({1'b0, fifo_count} + (CW + 1)'(inflight)) < DEPTH_L;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state    <= ST_INIT;
            clr_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            inflight <= accept && !req_we;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        req_ready   = 1'b0;
        accept      = 1'b0;
        clear_busy  = 1'b1;
        sram_csb    = 1'b1;
        sram_web    = 1'b1;
        sram_addr   = '0;
        sram_din    = '0;
        case (state)
            ST_INIT: begin
                clr_cnt_nxt = '0;
                state_nxt   = ST_CLEAR;
            end
            ST_CLEAR: begin
                sram_csb    = 1'b0;
                sram_web    = 1'b0;
                sram_addr   = clr_cnt;
                sram_din    = CLEAR_VALUE;
                clr_cnt_nxt = clr_cnt + S_INDEX'(1);
                if (clr_cnt == LAST_SET) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                clear_busy = 1'b0;
                req_ready  = req_we || rd_room;
                accept     = req_valid && req_ready;
                if (accept) begin
                    sram_csb  = 1'b0;
                    sram_web  = !req_we;
                    sram_addr = req_addr;
                    sram_din  = req_wdata;
                end
                if (clear_req) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                clr_cnt_nxt = '0;
                if (!inflight) state_nxt = ST_CLEAR;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign rsp_valid = (fifo_count != '0);

    rsp_fifo #(
        .WIDTH     (WIDTH),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk0      (clk0),
        .rst0      (rst0),
        .push      (inflight),
        .push_data (sram_dout),
        .pop       (rsp_valid && rsp_ready),
        .rd_data   (rsp_rdata),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: array model on the SRAM pins, a shadow-memory
// plus response-queue reference, and directed plus random request traffic.
module tb_sram_port_ctrl;

    localparam int         S_INDEX     = 4;
    localparam int         WIDTH       = 8;
    localparam int         RSP_DEPTH   = 3;
    localparam int         NUM_SETS    = 16;
    localparam logic [7:0] CLEAR_VALUE = 8'h5A;

    logic               clk0 = 1'b0;
    logic               rst0;
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [S_INDEX-1:0] req_addr;
    logic [WIDTH-1:0]   req_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_rdata;
    logic               clear_req;
    logic               clear_busy;
    logic               sram_csb;
    logic               sram_web;
    logic [S_INDEX-1:0] sram_addr;
    logic [WIDTH-1:0]   sram_din;
    logic [WIDTH-1:0]   sram_dout;

    sram_port_ctrl #(
        .S_INDEX     (S_INDEX),
        .WIDTH       (WIDTH),
        .CLEAR_VALUE (CLEAR_VALUE),
        .RSP_DEPTH   (RSP_DEPTH)
    ) dut (
        .clk0       (clk0),
        .rst0       (rst0),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    always #5 clk0 = ~clk0;

    // Array macro: read data only meaningful the cycle after a read sample.
    logic [WIDTH-1:0] smem [NUM_SETS];
    always @(posedge clk0) begin
        if (!sram_csb && !sram_web) smem[sram_addr] <= sram_din;
        if (!sram_csb && sram_web) sram_dout <= smem[sram_addr];
        else                       sram_dout <= 8'($urandom);
    end

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } rsp_t;

    rsp_t             exp_q[$];
    logic [WIDTH-1:0] shadow [NUM_SETS];
    int               mphase;
    int               cyc;
    int               n_pass;
    int               n_total;
    logic             m_acc;
    logic             m_pop;
    logic             m_clr;
    logic             m_we;
    logic [S_INDEX-1:0] m_addr;
    logic [WIDTH-1:0]   m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_reset();
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        chk("rst_clear_busy", 32'(clear_busy), 32'(1));
        chk("rst_sram_csb", 32'(sram_csb), 32'(1));
        chk("rst_sram_web", 32'(sram_web), 32'(1));
        chk("rst_sram_addr", 32'(sram_addr), 32'(0));
        chk("rst_sram_din", 32'(sram_din), 32'(0));
    endtask

    task automatic shadow_clear();
        for (int i = 0; i < NUM_SETS; i++) shadow[i] = CLEAR_VALUE;
    endtask

    task automatic observe();
        logic run;
        logic exp_ready;
        logic hd_ok;
        @(negedge clk0);
        m_acc = 1'b0;
        m_pop = 1'b0;
        m_clr = 1'b0;
        if (rst0) begin
            check_reset();
        end else begin
            run       = (mphase == NUM_SETS);
            exp_ready = run && (req_we || (exp_q.size() < RSP_DEPTH));
            hd_ok     = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc - 2);
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(hd_ok));
            chk("clear_busy", 32'(clear_busy), 32'(!run));
            m_acc  = req_valid && exp_ready;
            m_we   = req_we;
            m_addr = req_addr;
            m_data = req_wdata;
            if (mphase >= 0 && mphase < NUM_SETS) begin
                chk("sweep_csb", 32'(sram_csb), 32'(0));
                chk("sweep_web", 32'(sram_web), 32'(0));
                chk("sweep_addr", 32'(sram_addr), 32'(mphase));
                chk("sweep_din", 32'(sram_din), 32'(CLEAR_VALUE));
            end else begin
                chk("csb", 32'(sram_csb), 32'(!m_acc));
                chk("web", 32'(sram_web), 32'(m_acc ? !m_we : 1'b1));
                chk("addr", 32'(sram_addr), 32'(m_acc ? m_addr : '0));
                chk("din", 32'(sram_din), 32'(m_acc ? m_data : '0));
            end
            if (hd_ok) begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].data));
                m_pop = rsp_ready;
            end
            m_clr = run && clear_req;
        end
    endtask

    task automatic advance();
        @(posedge clk0);
        if (rst0) begin
            mphase = -1;
            exp_q.delete();
            shadow_clear();
        end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (m_acc) begin
                if (m_we) shadow[m_addr] = m_data;
                else exp_q.push_back('{data: shadow[m_addr], cyc: cyc});
            end
            if (m_clr) begin
                mphase = (m_acc && !m_we) ? -2 : -1;
                shadow_clear();
            end else if (mphase < NUM_SETS) begin
                mphase++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        observe();
        advance();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        clear_req = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [S_INDEX-1:0] a, input logic [WIDTH-1:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        cyc = 0;
        mphase = -1;
        rst0 = 1'b1;
        rsp_ready = 1'b1;
        idle();
        shadow_clear();
        repeat (3) step();
        rst0 = 1'b0;

        // INIT plus 16-cycle sweep; the 18th cycle must be the first ready one
        repeat (17) step();
        chk("run_after_sweep", 32'(mphase), 32'(NUM_SETS));

        drive(1'b1, 4'd5, 8'h01);
        step();
        drive(1'b0, 4'd5, 8'h00);
        step();
        idle();
        repeat (4) step();

        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'($urandom), 8'h00);
            step();
        end
        idle();
        repeat (4) step();

        // Backpressured reads: only three may be outstanding; writes still go
        rsp_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(i == 4, 4'($urandom), 8'($urandom));
            step();
        end
        chk("bp_outstanding", 32'(exp_q.size()), 32'(RSP_DEPTH));
        idle();
        rsp_ready = 1'b1;
        repeat (6) step();

        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom);
            req_we    = ($urandom_range(0, 2) == 0);
            req_addr  = 4'($urandom);
            req_wdata = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            clear_req = ($urandom_range(0, 59) == 0);
            step();
        end
        idle();
        rsp_ready = 1'b1;
        repeat (40) step();

        // Clear while a read is in flight: the older response must survive
        drive(1'b0, 4'd3, 8'h00);
        step();
        idle();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (18) step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'(i * 5), 8'h00);
            step();
        end
        idle();
        repeat (4) step();

        // Reset while the sweep is at set 7
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 40 && mphase != 7; i++) step();
        chk("reached_set7", 32'(mphase), 32'(7));
        observe();
        #2 rst0 = 1'b1;
        #1 check_reset();
        advance();
        step();
        rst0 = 1'b0;
        repeat (20) step();
        drive(1'b1, 4'd9, 8'hC3);
        step();
        drive(1'b0, 4'd9, 8'h00);
        step();
        drive(1'b0, 4'd2, 8'h00);
        step();
        idle();
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Initiator-side controller for the team's single-port flop/SRAM array macros: it converts a valid/ready request channel from cache logic into the array's chip-select/write-enable port protocol and returns read data on a backpressured response channel. On reset, and on demand, it sweeps every set with a clear value so tag/valid arrays start in a known state. It sits between a cache controller and one array instance (tag, valid, dirty or data way).

## Interface
- S_INDEX, 4, set-index width; NUM_SETS = 2**S_INDEX
- WIDTH, 1, data width
- CLEAR_VALUE, '0, word written to every set by a clear sweep
- RSP_DEPTH, 3, response FIFO depth (≥3 for full read throughput)

- clk0  in  1  clock
- rst0  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid && ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  S_INDEX  set index
- req_wdata  in  WIDTH  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes rsp_rdata
- rsp_rdata  out  WIDTH  read data, in read-issue order
- clear_req  in  1  pulse: start a clear sweep
- clear_busy  out  1  high in INIT, DRAIN, CLEAR
- sram_csb  out  1  array chip select, active-low
- sram_web  out  1  array write enable, active-low
- sram_addr  out  S_INDEX  array address
- sram_din  out  WIDTH  array write data
- sram_dout  in  WIDTH  array read data

## Operation
- Array port contract: array samples csb/web/addr/din at posedge when csb=0; write commits at next posedge; read data valid on sram_dout the whole cycle after the sampling edge.
- States: INIT -> CLEAR -> RUN; RUN -> DRAIN on clear_req; DRAIN -> CLEAR when no read in flight; CLEAR -> RUN after last set.
- INIT: one cycle after reset release; all SRAM pins idle (csb=1, web=1, addr=0, din=0).
- CLEAR: counter 0..NUM_SETS-1; each cycle csb=0, web=0, addr=counter, din=CLEAR_VALUE; req_ready=0. Exit on counter wrap from NUM_SETS-1.
- RUN: sram_csb = !(req_valid && req_ready); web = !req_we; addr/din pass request combinationally; idle pins as INIT when no accept.
- req_ready in RUN: writes always 1; reads 1 iff fifo_count + inflight < RSP_DEPTH (inflight = read accepted previous cycle). req_ready never depends on rsp_ready.
- In-flight read: sram_dout pushed into response FIFO at end of the cycle after issue.
- clear_req in RUN: req_ready drops the following cycle; request accepted in the same cycle as clear_req completes normally. clear_req outside RUN ignored.
- Response FIFO not flushed by clear; pending responses still drain during CLEAR.
- Read-after-write, any spacing including back-to-back same address: returns new data (array commit precedes read sampling); controller adds no forwarding.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, clear_busy=1, sram_csb=1, sram_web=1, sram_addr=0, sram_din=0; state INIT, FIFO empty.
- Read latency: accept in cycle N -> rsp_valid earliest cycle N+2.
- Throughput: one request per cycle with rsp_ready=1.
- Clear duration: NUM_SETS cycles; from reset release to first req_ready = NUM_SETS+1 cycles.
- FIFO push and pop same cycle: count unchanged; full FIFO stalls reads only.
- rst0 mid-sweep or mid-read: immediate return to reset values; in-flight read and FIFO contents discarded.

## Structure
- Package sram_ctrl_pkg: state enum (INIT, CLEAR, RUN, DRAIN).
- Sub-module rsp_fifo: synchronous FIFO, parameters WIDTH and RSP_DEPTH, count output, async rst0.

## Test plan
- Reset release, S_INDEX=4, CLEAR_VALUE=0: sweep writes addr 0..15 on cycles 2..17, req_ready first high cycle 18, clear_busy low same cycle.
- Write addr 5 = 1, then read addr 5 next cycle -> rsp_rdata=1 two cycles after read accept.
- 8 back-to-back reads, rsp_ready=1 -> req_ready stays high, 8 responses in order on consecutive cycles.
- rsp_ready=0, issue reads -> exactly 3 accepted, req_ready low for reads, writes still accepted; release rsp_ready -> 3 responses in order.
- clear_req while read in flight -> DRAIN one cycle, sweep 16 cycles, prior response delivered, later read of any set returns CLEAR_VALUE.
- rst0 asserted mid-sweep at counter=7 -> outputs return to reset values immediately, sweep restarts from addr 0.
